// File: rtl/exp_unit_arbiter.sv
// exp_unit_arbiter: round-robin arbiter sharing one floating_point_exp unit among NUM_REQ requesters.
// Define EXP_ARB_TIMEOUT_EN to enable the WAIT watchdog (TIMEOUT_CYCLES) and the sticky timeout_err flag.
module exp_unit_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_x,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]         resp_data,
  output logic                          start_exp,
  output logic [DATA_WIDTH-1:0]         x,
  input  logic [DATA_WIDTH-1:0]         exp_out_reg,
  input  logic                          softmax_output_ready,
  output logic                          busy,
  output logic                          timeout_err
);
  localparam int PW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  state_e                  state_q;
  logic [PW-1:0]           rr_ptr_q, owner_q, gnt_d;
  logic                    gnt_vld_d, start_q, tmo;
  logic [NUM_REQ-1:0]      ack_q, rv_q;
  logic [DATA_WIDTH-1:0]   data_q, x_q;
  // Scan from the far end so the candidate nearest rr_ptr+1 is assigned last and wins.
  always_comb begin
    gnt_vld_d = 1'b0;
    gnt_d     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[PW'((int'(rr_ptr_q) + k) % NUM_REQ)]) begin
        gnt_vld_d = 1'b1;
        gnt_d     = PW'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
  end
`ifdef EXP_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  logic          err_q;
  assign tmo = (state_q == WAIT) && !softmax_output_ready && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= (state_q == ISSUE) ? '0 : (state_q == WAIT) ? cnt_q + 1'b1 : cnt_q;
      err_q <= err_q | tmo;
    end
  end
  assign timeout_err = err_q;
`else
  logic unused_cfg;
  assign unused_cfg  = TIMEOUT_CYCLES[0];
  assign tmo         = 1'b0;
  assign timeout_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= PW'(NUM_REQ - 1);
      owner_q  <= '0;
      ack_q    <= '0;
      rv_q     <= '0;
      data_q   <= '0;
      start_q  <= 1'b0;
      x_q      <= '0;
    end else begin
      ack_q   <= '0;
      rv_q    <= '0;
      start_q <= 1'b0;
      case (state_q)
        IDLE: if (gnt_vld_d) begin
          state_q <= ISSUE;
          owner_q <= gnt_d;
          x_q     <= req_x[gnt_d*DATA_WIDTH +: DATA_WIDTH];
          ack_q   <= NUM_REQ'(1) << gnt_d;
          start_q <= 1'b1;
        end
        ISSUE: state_q <= WAIT;
        WAIT: if (softmax_output_ready || tmo) begin
          state_q <= RESP;
          data_q  <= softmax_output_ready ? exp_out_reg : '1;
          rv_q    <= NUM_REQ'(1) << owner_q;
        end
        RESP: begin
          state_q  <= IDLE;
          rr_ptr_q <= owner_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign req_ack    = ack_q;
  assign resp_valid = rv_q;
  assign resp_data  = data_q;
  assign start_exp  = start_q;
  assign x          = x_q;
  assign busy       = (state_q != IDLE);
endmodule
